// File: rtl/barrett_reducer_pkg.sv
// Shared constants and helpers for the Barrett reducer.
// Purpose : width helpers and latency calculation, so the top level and any
//           wrapper agree on the derived sizes.
// Contents: calc_loglogq - width of the B port for a given LOGQ
//           calc_lat     - pipeline latency from the stage-enable flags
//           t/m/r/p_width- widths of the shifted product, quotient, remainder
//                          and the t*MU product
package barrett_pkg;

  // Number of stage slots carried by the q/MU/B side pipeline.
  localparam int NUM_QSTAGES = 7;

  function automatic int calc_loglogq(input int logq);
    return $clog2(logq + 1);
  endfunction

  function automatic int calc_lat(input int ff_in, input int ff_shf, input int ff_mul,
                                  input int use_csa, input int ff_csa, input int ff_neg,
                                  input int ff_corr, input int ff_out);
    return ff_in + ff_shf + 2 * ff_mul + use_csa * ff_csa + ff_neg + ff_corr + ff_out;
  endfunction

  function automatic int t_width(input int logq);
    return logq + 1;
  endfunction

  function automatic int m_width(input int logq);
    return logq + 1;
  endfunction

  // The remainder is kept two bits wider than q so that values up to 3q fit.
  function automatic int r_width(input int logq);
    return logq + 2;
  endfunction

  function automatic int p_width(input int logq);
    return t_width(logq) + m_width(logq);
  endfunction

endpackage

// File: rtl/barrett_reducer_pipe_reg.sv
// Optional pipeline stage.
// Purpose : a register with asynchronous active-low clear when EN=1, a plain
//           wire when EN=0. Every optional stage of the reducer uses this.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low clear
//           d_i   - stage input
//           q_o   - stage output (registered or passed through)
module pipe_reg #(
  parameter int WIDTH = 1,
  parameter bit EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (EN) begin : g_reg
    logic [WIDTH-1:0] data_q;

    // Stage register, cleared asynchronously so in-flight data is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else begin
        data_q <= d_i;
      end
    end

    assign q_o = data_q;
  end else begin : g_wire
    logic unused_clk_s;

    assign q_o          = d_i;
    assign unused_clk_s = clk ^ rst_n;
  end

endmodule

// File: rtl/barrett_reducer.sv
// Fully pipelined Barrett modular reducer.
// Purpose : T = C mod q for a 2*LOGQ-bit C, one operand set per cycle,
//           fixed latency LAT, no handshake.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears every stage
//           C     - value to reduce, C < 2^(2B)
//           qH    - modulus, zero-extended to LOGQ bits
//           MU    - floor(2^(2B)/q)
//           B     - bit length of q (1..LOGQ)
//           T     - reduced result
module barrett_reducer
  import barrett_pkg::*;
#(
  parameter int LOGQ    = 64,
  parameter int LOGQH   = 64,
  parameter int PIPE_Q  = 1,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SHF  = 1,
  parameter int FF_MUL  = 1,
  parameter int USE_CSA = 1,
  parameter int FF_CSA  = 1,
  parameter int FF_NEG  = 0,
  parameter int FF_CORR = 0,
  parameter int FF_OUT  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*LOGQ-1:0]             C,
  input  logic [LOGQH-1:0]              qH,
  input  logic [LOGQ:0]                 MU,
  input  logic [calc_loglogq(LOGQ)-1:0] B,
  output logic [LOGQ-1:0]               T
);

  localparam int LAT = calc_lat(FF_IN, FF_SHF, FF_MUL, USE_CSA, FF_CSA, FF_NEG, FF_CORR, FF_OUT);
  localparam int LB  = calc_loglogq(LOGQ);
  localparam int TW  = t_width(LOGQ);
  localparam int MW  = m_width(LOGQ);
  localparam int RW  = r_width(LOGQ);
  localparam int PW  = p_width(LOGQ);
  localparam int QW  = LOGQ + MW + LB;
  localparam logic [RW-1:0] ONE = {{(RW-1){1'b0}}, 1'b1};

  // Bit i enables side-pipeline slot i, matching the datapath stage order.
  localparam logic [NUM_QSTAGES-1:0] STAGE_EN = {
    FF_CORR != 0, FF_NEG != 0, (USE_CSA != 0) && (FF_CSA != 0),
    FF_MUL != 0, FF_MUL != 0, FF_SHF != 0, FF_IN != 0};

  logic [LOGQ-1:0]     q_ext_s;
  logic [QW-1:0]       qmb_s [0:NUM_QSTAGES];
  logic [LB-1:0]       b1_s, b2_s, b3_s;
  logic [MW-1:0]       mu2_s;
  logic [LOGQ-1:0]     q3_s, q6_s, q7_s;
  logic [2*LOGQ-1:0]   c1_s, shf_s;
  logic [TW+RW-1:0]    st2_s;
  logic [PW+RW-1:0]    st3_s;
  logic [2*RW-1:0]     st4_s, vec_s, st5_s;
  logic [PW-1:0]       prod_s, msh_s;
  logic [MW-1:0]       m_s;
  logic [RW-1:0]       mq_s, va_s, vb_s, r_s, r6_s, r1_s, r7_s, tfull_s;
  logic                unused_bits_s;

  // Zero-extend the modulus to the full datapath width.
  always_comb begin
    q_ext_s             = '0;
    q_ext_s[LOGQH-1:0]  = qH;
  end

  // q/MU/B travel alongside their C; with PIPE_Q=0 every slot is a wire.
  assign qmb_s[0] = {q_ext_s, MU, B};
  for (genvar i = 0; i < NUM_QSTAGES; i++) begin : g_qmb
    pipe_reg #(.WIDTH(QW), .EN((PIPE_Q != 0) && STAGE_EN[i])) u_qmb (
      .clk(clk), .rst_n(rst_n), .d_i(qmb_s[i]), .q_o(qmb_s[i+1]));
  end

  assign b1_s  = qmb_s[1][LB-1:0];
  assign b2_s  = qmb_s[2][LB-1:0];
  assign mu2_s = qmb_s[2][LB +: MW];
  assign b3_s  = qmb_s[3][LB-1:0];
  assign q3_s  = qmb_s[3][QW-1 -: LOGQ];
  assign q6_s  = qmb_s[6][QW-1 -: LOGQ];
  assign q7_s  = qmb_s[7][QW-1 -: LOGQ];

  pipe_reg #(.WIDTH(2*LOGQ), .EN(FF_IN != 0)) u_in (
    .clk(clk), .rst_n(rst_n), .d_i(C), .q_o(c1_s));

  // t = C >> (B-1). Only the low RW bits of C matter for r mod 2^RW.
  assign shf_s = c1_s >> (b1_s - LB'(1));

  pipe_reg #(.WIDTH(TW+RW), .EN(FF_SHF != 0)) u_shf (
    .clk(clk), .rst_n(rst_n), .d_i({shf_s[TW-1:0], c1_s[RW-1:0]}), .q_o(st2_s));

  assign prod_s = {{MW{1'b0}}, st2_s[RW +: TW]} * {{TW{1'b0}}, mu2_s};

  pipe_reg #(.WIDTH(PW+RW), .EN(FF_MUL != 0)) u_mul1 (
    .clk(clk), .rst_n(rst_n), .d_i({prod_s, st2_s[RW-1:0]}), .q_o(st3_s));

  // B+1 is widened by one bit so B=LOGQ cannot wrap when LOGQ+1 is a power of two.
  assign msh_s = st3_s[RW +: PW] >> ({1'b0, b3_s} + (LB+1)'(1));
  assign m_s   = msh_s[MW-1:0];
  assign mq_s  = {1'b0, m_s} * {2'b00, q3_s};

  pipe_reg #(.WIDTH(2*RW), .EN(FF_MUL != 0)) u_mul2 (
    .clk(clk), .rst_n(rst_n), .d_i({mq_s, st3_s[RW-1:0]}), .q_o(st4_s));

  // C - m*q as C + ~mq + 1: either a 3:2 carry-save pair or plain two's complement.
  always_comb begin
    va_s = st4_s[RW-1:0];
    vb_s = ~st4_s[RW +: RW] + ONE;
    if (USE_CSA != 0) begin
      va_s = st4_s[RW-1:0] ^ ~st4_s[RW +: RW] ^ ONE;
      vb_s = (st4_s[RW-1:0] & ~st4_s[RW +: RW]) | (st4_s[RW-1:0] & ONE)
           | (~st4_s[RW +: RW] & ONE);
      vb_s = {vb_s[RW-2:0], 1'b0};
    end else begin
      vb_s = ~st4_s[RW +: RW] + ONE;
    end
  end

  assign vec_s = {vb_s, va_s};

  pipe_reg #(.WIDTH(2*RW), .EN((USE_CSA != 0) && (FF_CSA != 0))) u_csa (
    .clk(clk), .rst_n(rst_n), .d_i(vec_s), .q_o(st5_s));

  assign r_s = st5_s[RW-1:0] + st5_s[RW +: RW];

  pipe_reg #(.WIDTH(RW), .EN(FF_NEG != 0)) u_neg (
    .clk(clk), .rst_n(rst_n), .d_i(r_s), .q_o(r6_s));

  // First conditional subtraction brings r from [0,3q) into [0,2q).
  always_comb begin
    r1_s = r6_s;
    if ((CORRECT != 0) && (r6_s >= {2'b00, q6_s})) begin
      r1_s = r6_s - {2'b00, q6_s};
    end else begin
      r1_s = r6_s;
    end
  end

  pipe_reg #(.WIDTH(RW), .EN(FF_CORR != 0)) u_corr (
    .clk(clk), .rst_n(rst_n), .d_i(r1_s), .q_o(r7_s));

  // Second conditional subtraction lands in [0,q).
  always_comb begin
    tfull_s = r7_s;
    if ((CORRECT != 0) && (r7_s >= {2'b00, q7_s})) begin
      tfull_s = r7_s - {2'b00, q7_s};
    end else begin
      tfull_s = r7_s;
    end
  end

  pipe_reg #(.WIDTH(LOGQ), .EN(FF_OUT != 0)) u_out (
    .clk(clk), .rst_n(rst_n), .d_i(tfull_s[LOGQ-1:0]), .q_o(T));

  // Fields of the side pipeline and truncated high bits that no stage reads.
  assign unused_bits_s = ^{qmb_s[1], qmb_s[2], qmb_s[3], qmb_s[4], qmb_s[5], qmb_s[6],
                           qmb_s[7], b2_s, shf_s[2*LOGQ-1:TW], msh_s[PW-1:MW],
                           tfull_s[RW-1:LOGQ]};

endmodule

// File: tb/tb_barrett_reducer.sv
module tb_barrett_reducer;

  localparam int MAXE     = 2048;
  localparam int LAT_MAIN = 1 + 1 + 2 + 1 + 0 + 0 + 1;
  localparam int LAT_RAW  = LAT_MAIN;
  localparam int LAT_ALT  = 1 + 1 + 2 + 0 + 1 + 1 + 1;
  localparam int LAT_COMB = 0;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] C     = '0;
  logic [63:0]  qH    = '0;
  logic [64:0]  MU    = '0;
  logic [6:0]   B     = '0;
  logic [63:0]  t_main, t_raw, t_alt, t_comb;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int inval_upto = 1 << 30;

  logic [127:0] rec_c   [MAXE];
  logic [63:0]  rec_q   [MAXE];
  logic [64:0]  rec_mu  [MAXE];
  logic [6:0]   rec_b   [MAXE];
  logic [63:0]  rec_exp [MAXE];
  bit           rec_vld [MAXE];

  barrett_reducer dut_main (.clk(clk), .rst_n(rst_n), .C(C), .qH(qH), .MU(MU), .B(B), .T(t_main));

  barrett_reducer #(.CORRECT(0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .C(C), .qH(qH), .MU(MU), .B(B), .T(t_raw));

  barrett_reducer #(.USE_CSA(1), .FF_CSA(0), .FF_NEG(1), .FF_CORR(1)) dut_alt (
    .clk(clk), .rst_n(rst_n), .C(C), .qH(qH), .MU(MU), .B(B), .T(t_alt));

  barrett_reducer #(.FF_IN(0), .FF_SHF(0), .FF_MUL(0), .USE_CSA(0), .FF_CSA(0),
                    .FF_NEG(0), .FF_CORR(0), .FF_OUT(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .C(C), .qH(qH), .MU(MU), .B(B), .T(t_comb));

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [63:0] golden(input logic [127:0] c, input logic [63:0] q);
    logic [127:0] r;
    r = c % {64'd0, q};
    return r[63:0];
  endfunction

  // Uncorrected Barrett estimate straight from the defining formulas.
  function automatic logic [63:0] barrett_raw(input logic [127:0] c, input logic [63:0] q,
                                              input logic [64:0] mu, input logic [6:0] b);
    int           bi;
    logic [127:0] tf;
    logic [129:0] p;
    logic [64:0]  t;
    logic [64:0]  m;
    logic [65:0]  r;
    bi = int'(b);
    tf = c >> (bi - 1);
    t  = tf[64:0];
    p  = {65'd0, t} * {65'd0, mu};
    p  = p >> (bi + 1);
    m  = p[64:0];
    r  = c[65:0] - ({1'b0, m} * {2'd0, q});
    return r[63:0];
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (edge %0d)", nm, got, want, edge_n);
    end
  endtask

  task automatic chk_path(input string nm, input logic [63:0] got, input int lat, input bit raw);
    int k;
    k = edge_n + 1 - lat;
    if (k > inval_upto && k < MAXE && rec_vld[k]) begin
      if (raw) begin
        check(nm, got, barrett_raw(rec_c[k], rec_q[k], rec_mu[k], rec_b[k]));
        if (rec_q[k][63:62] == 2'b00) begin
          check({nm, "_cong"}, got % rec_q[k], rec_exp[k]);
          check({nm, "_range"}, {63'd0, got < 3 * rec_q[k]}, 64'd1);
        end
      end else begin
        check(nm, got, rec_exp[k]);
      end
    end
  endtask

  // Single compare process: every DUT against the model at its own latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_main", t_main, 64'd0);
      check("rst_raw", t_raw, 64'd0);
      check("rst_alt", t_alt, 64'd0);
    end else begin
      chk_path("main", t_main, LAT_MAIN, 1'b0);
      chk_path("raw", t_raw, LAT_RAW, 1'b1);
      chk_path("alt", t_alt, LAT_ALT, 1'b0);
      chk_path("comb", t_comb, LAT_COMB, 1'b0);
    end
  end

  task automatic issue(input logic [127:0] c, input logic [63:0] q, input logic [64:0] mu,
                       input logic [6:0] b, input logic [63:0] expv);
    int idx;
    @(posedge clk);
    #1;
    C = c; qH = q; MU = mu; B = b;
    idx = edge_n + 1;
    if (idx < MAXE) begin
      rec_c[idx] = c; rec_q[idx] = q; rec_mu[idx] = mu; rec_b[idx] = b;
      rec_exp[idx] = expv; rec_vld[idx] = 1'b1;
    end
  endtask

  task automatic issue_rand();
    int           b;
    int           sel;
    logic [63:0]  q, k;
    logic [128:0] pw, qt;
    logic [127:0] c;
    b = $urandom_range(1, 64);
    q = {$urandom, $urandom};
    q = q >> (64 - b);
    q[b-1] = 1'b1;
    if (b == 64) q[0] = 1'b1;
    pw = 129'd1 << (2 * b);
    qt = pw / {65'd0, q};
    sel = $urandom_range(0, 7);
    case (sel)
      0: c = '0;
      1: begin
        k = {$urandom, $urandom};
        k = k >> (64 - b);
        c = {64'd0, k} * {64'd0, q};
      end
      2: c = ({64'd0, q} * {64'd0, q}) - 128'd1;
      default: begin
        c = {$urandom, $urandom, $urandom, $urandom};
        c = c >> (128 - 2 * b);
      end
    endcase
    issue(c, q, qt[64:0], 7'(b), golden(c, q));
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_main", t_main, 64'd0);
    check("async_rst_raw", t_raw, 64'd0);
    check("async_rst_alt", t_alt, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    inval_upto = edge_n;
  endtask

  initial begin
    logic [63:0]  qb;
    logic [127:0] cb;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    inval_upto = edge_n;
    check("lat_main", 64'(dut_main.LAT), 64'(LAT_MAIN));
    check("lat_alt", 64'(dut_alt.LAT), 64'(LAT_ALT));
    check("lat_comb", 64'(dut_comb.LAT), 64'(LAT_COMB));

    // Small modulus q=17, hand-computed results.
    issue(128'd100, 64'd17, 65'd60, 7'd5, 64'd15);
    issue(128'd0,   64'd17, 65'd60, 7'd5, 64'd0);
    issue(128'd17,  64'd17, 65'd60, 7'd5, 64'd0);
    issue(128'd288, 64'd17, 65'd60, 7'd5, 64'd16);

    // Full-width modulus; 2^64 = 59 mod q, so 2^128-1 = 3480 mod q.
    qb = 64'hFFFF_FFFF_FFFF_FFC5;
    cb = {64'd0, qb - 64'd1} * {64'd0, qb - 64'd1};
    issue(cb, qb, 65'h1_0000_0000_0000_003B, 7'd64, 64'd1);
    cb = '1;
    issue(cb, qb, 65'h1_0000_0000_0000_003B, 7'd64, 64'd3480);

    // q=1
    issue(128'd3, 64'd1, 65'd4, 7'd1, 64'd0);

    for (int i = 0; i < 600; i++) issue_rand();
    mid_reset();
    for (int i = 0; i < 600; i++) issue_rand();

    repeat (LAT_ALT + 4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
